// File: rtl/alu_pipe_if.sv
// alu_pipe_if -- request/response bundle for alu_pipe.
//   Request side : in_valid/in_ready handshake with RS1, RS2, Funct3, Funct7,
//                  opcode, Imm_reg.
//   Response side: out_valid/out_ready handshake with RD, out_err.
//   master modport: the producer/consumer around the ALU.
//   slave  modport: the ALU itself.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] RS1;
    logic [WIDTH-1:0] RS2;
    logic [2:0]       Funct3;
    logic [6:0]       Funct7;
    logic [6:0]       opcode;
    logic [11:0]      Imm_reg;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] RD;
    logic             out_err;

    modport master (
        output in_valid, RS1, RS2, Funct3, Funct7, opcode, Imm_reg, out_ready,
        input  in_ready, out_valid, RD, out_err
    );

    modport slave (
        input  in_valid, RS1, RS2, Funct3, Funct7, opcode, Imm_reg, out_ready,
        output in_ready, out_valid, RD, out_err
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe -- two-stage RV32I-style integer ALU with valid/ready flow control.
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : alu_pipe_if.slave (request in, result out)
// Stage S1 holds the decoded op and operands, stage S2 holds RD/out_err.
// Unsupported requests still flow through the pipe and come out with
// out_err=1, RD=0.
// Optional feature: define ALU_PIPE_MUL_EN to add MUL/MULH/MULHU
// (R-type, Funct7=0000001). Without it no multiplier is built.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
`ifdef ALU_PIPE_MUL_EN
    localparam logic [6:0] F7_MUL  = 7'b0000001;
`endif

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHU, OP_ERR
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    function automatic op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    logic             s1_vld_q, s2_vld_q;
    s1_t              s1_q, s1_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             err_q, err_d;
    logic             s2_free;

    // S2 can take a new entry when it is empty or its result leaves now.
    assign s2_free       = !s2_vld_q || bus.out_ready;
    assign bus.in_ready  = !rst && (!s1_vld_q || s2_free);
    assign bus.out_valid = s2_vld_q;
    assign bus.RD        = rd_q;
    assign bus.out_err   = err_q;

    // ---------------- decode (into S1) ----------------
    always_comb begin
        s1_d.op = OP_ERR;
        s1_d.a  = bus.RS1;
        // Size cast of a signed value sign-extends (or truncates for WIDTH=8).
        s1_d.b  = (bus.opcode == OPC_I) ? WIDTH'($signed(bus.Imm_reg)) : bus.RS2;
        if (bus.opcode == OPC_R) begin
            if (bus.Funct7 == F7_BASE) begin
                s1_d.op = base_op(bus.Funct3);
            end else if (bus.Funct7 == F7_ALT) begin
                if (bus.Funct3 == 3'b000)      s1_d.op = OP_SUB;
                else if (bus.Funct3 == 3'b101) s1_d.op = OP_SRA;
            end
`ifdef ALU_PIPE_MUL_EN
            else if (bus.Funct7 == F7_MUL) begin
                if (bus.Funct3 == 3'b000)      s1_d.op = OP_MUL;
                else if (bus.Funct3 == 3'b001) s1_d.op = OP_MULH;
                else if (bus.Funct3 == 3'b011) s1_d.op = OP_MULHU;
            end
`endif
        end else if (bus.opcode == OPC_I) begin
            // Only the shift-right form qualifies on Funct7; there is no SUBI.
            if (bus.Funct3 == 3'b101) begin
                if (bus.Funct7 == F7_BASE)     s1_d.op = OP_SRL;
                else if (bus.Funct7 == F7_ALT) s1_d.op = OP_SRA;
            end else begin
                s1_d.op = base_op(bus.Funct3);
            end
        end
    end

    // ---------------- execute (into S2) ----------------
    logic [SHW-1:0] shamt;
    assign shamt = s1_q.b[SHW-1:0];

`ifdef ALU_PIPE_MUL_EN
    // One (WIDTH+1)-bit signed multiplier covers both signednesses: MULH
    // sign-extends the operands, MUL/MULHU zero-extend them. The low WIDTH
    // bits are identical either way.
    logic                      mul_sgn;
    logic signed [WIDTH:0]     mul_a, mul_b;
    logic signed [2*WIDTH+1:0] prod_unused_top;
    assign mul_sgn = (s1_q.op == OP_MULH);
    assign mul_a   = {mul_sgn & s1_q.a[WIDTH-1], s1_q.a};
    assign mul_b   = {mul_sgn & s1_q.b[WIDTH-1], s1_q.b};
    assign prod_unused_top = mul_a * mul_b;
`endif

    always_comb begin
        rd_d  = '0;
        err_d = 1'b0;
        case (s1_q.op)
            OP_ADD:  rd_d = s1_q.a + s1_q.b;
            OP_SUB:  rd_d = s1_q.a - s1_q.b;
            OP_SLL:  rd_d = s1_q.a << shamt;
            OP_SLT:  rd_d = {{(WIDTH-1){1'b0}}, $signed(s1_q.a) < $signed(s1_q.b)};
            OP_SLTU: rd_d = {{(WIDTH-1){1'b0}}, s1_q.a < s1_q.b};
            OP_XOR:  rd_d = s1_q.a ^ s1_q.b;
            OP_SRL:  rd_d = s1_q.a >> shamt;
            OP_SRA:  rd_d = $signed(s1_q.a) >>> shamt;
            OP_OR:   rd_d = s1_q.a | s1_q.b;
            OP_AND:  rd_d = s1_q.a & s1_q.b;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:   rd_d = prod_unused_top[WIDTH-1:0];
            OP_MULH,
            OP_MULHU: rd_d = prod_unused_top[2*WIDTH-1:WIDTH];
`endif
            default: begin
                rd_d  = '0;
                err_d = 1'b1;
            end
        endcase
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            rd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            if (s2_free) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    rd_q  <= rd_d;
                    err_q <= err_d;
                end
            end
            // in_ready (outside reset) means S1 is empty or draining this cycle.
            if (bus.in_ready) s1_vld_q <= bus.in_valid;
        end
    end

    // Operand payload needs no reset; it is qualified by s1_vld_q.
    always_ff @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) s1_q <= s1_d;
    end
endmodule
